// File: rtl/imm_encoder_seq.sv
// imm_encoder_seq: packs register fields and immediates into RV32I words over a valid/ready stream
`timescale 1ns/1ps
module imm_encoder_seq #(
  parameter bit RANGE_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err
);
  localparam logic [2:0] K_LOAD = 3'b000, K_LOADU = 3'b001, K_STORE = 3'b010;
  localparam logic [2:0] K_BRANCH = 3'b100, K_JALR = 3'b101, K_LI = 3'b111;
  typedef enum logic {S_IDLE, S_SECOND} state_t;
  state_t state, state_nx;
  logic [31:0] second, word, lui, addi0, addi2;
  logic [19:0] hi;
  logic s12, u12, b13, ok, bad, two, acc;
  always_comb begin
    s12 = imm[31:11] == '0 || imm[31:11] == '1;
    u12 = imm[31:12] == '0;
    b13 = (imm[31:12] == '0 || imm[31:12] == '1) && !imm[0];
    ok = kind == K_LOADU ? u12 : kind == K_BRANCH ? b13 : kind == K_LI ? 1'b1 : s12;
    bad = kind == 3'b011 || kind == 3'b110 || (RANGE_CHECK && !ok);
    hi = imm[31:12] + {19'd0, imm[11]};
    lui = {hi, rd, 7'b0110111};
    addi0 = {imm[11:0], 5'd0, 3'b000, rd, 7'b0010011};
    addi2 = {imm[11:0], rd, 3'b000, rd, 7'b0010011};
    two = kind == K_LI && !s12 && imm[11:0] != '0;
    word = (kind == K_LOAD || kind == K_LOADU) ? {imm[11:0], rs1, funct3, rd, 7'b0000011}
         : kind == K_STORE  ? {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}
         : kind == K_BRANCH ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011}
         : kind == K_JALR   ? {imm[11:0], rs1, 3'b000, rd, 7'b1100111}
         : s12 ? addi0 : lui;
  end
  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == S_IDLE ? ((acc && !bad && two) ? S_SECOND : S_IDLE)
             : ((out_valid && out_ready) ? S_IDLE : S_SECOND);
  always_comb begin
    in_ready = state == S_IDLE && (!out_valid || out_ready);
    acc = in_valid && in_ready;
  end
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      err <= 1'b0;
      second <= '0;
    end else begin
      err <= acc && bad;
      if (acc && !bad) begin
        out_valid <= 1'b1;
        out_instr <= word;
        second <= addi2;
      end else if (state == S_SECOND && out_valid && out_ready) begin
        out_instr <= second;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
endmodule
